// File: rtl/fifo_burst_checker.sv
// Read-domain consumer for the FWFT loopback FIFO: drains fixed-length bursts
// and checks each word against an incrementing reference sequence.
module fifo_burst_checker #(
    parameter int C_WIDTH   = 32,
    parameter int BURST_LEN = 256,
    parameter int TIMEOUT   = 1024,
    parameter int ERR_W     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fifo_full,
    input  logic [C_WIDTH-1:0]                 RD_DATA,
    input  logic                               RD_EMPTY,
    output logic                               RD_EN,
    output logic                               busy,
    output logic                               burst_done,
    output logic                               timeout,
    output logic                               err_flag,
    output logic [ERR_W-1:0]                   err_cnt,
    output logic [$clog2(BURST_LEN+1)-1:0]     word_cnt,
    output logic [C_WIDTH-1:0]                 expect_data,
    output logic [C_WIDTH-1:0]                 first_err_data
);

    localparam int WC_W = $clog2(BURST_LEN + 1);
    localparam int ST_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ST_W-1:0] stall_cnt;
    logic            last_word;
    logic            stall_expire;

    assign RD_EN      = (state == READ) & ~RD_EMPTY;
    assign busy       = (state == READ);
    assign burst_done = (state == DONE);

    // Compare against the pre-increment values so the terminal event lands on the same edge.
    assign last_word    = (word_cnt == WC_W'(BURST_LEN - 1));
    assign stall_expire = (stall_cnt == ST_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fifo_full) state_nxt = READ;
            READ: begin
                if (RD_EN && last_word)
                    state_nxt = DONE;
                else if (RD_EMPTY && stall_expire)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout        <= 1'b0;
            err_flag       <= 1'b0;
            err_cnt        <= '0;
            word_cnt       <= '0;
            expect_data    <= '0;
            first_err_data <= '0;
            stall_cnt      <= '0;
        end else begin
            if (state == IDLE && fifo_full) begin
                word_cnt  <= '0;
                stall_cnt <= '0;
            end
            if (state == READ) begin
                if (RD_EN) begin
                    word_cnt  <= word_cnt + WC_W'(1);
                    stall_cnt <= '0;
                    if (RD_DATA == expect_data) begin
                        expect_data <= expect_data + C_WIDTH'(1);
                    end else begin
                        // Resync to the observed word so one discontinuity is one error.
                        expect_data <= RD_DATA + C_WIDTH'(1);
                        err_flag    <= 1'b1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + ERR_W'(1);
                        if (!err_flag)
                            first_err_data <= RD_DATA;
                    end
                end else begin
                    stall_cnt <= stall_cnt + ST_W'(1);
                    if (stall_expire)
                        timeout <= 1'b1;
                end
            end
        end
    end

endmodule
